// File: rtl/ddr_wr_pkg.sv
// ddr_wr_pkg: shared types and constants for the write-DDR burst controller.
//   wr_state_t     : burst FSM states (IDLE / AW / W / B)
//   AXI_RESP_OKAY  : AXI OKAY response code
//   BYTES_PER_BEAT : bytes per beat for the default 128-bit data path
//   BURST_BYTES    : bytes per burst for the default 16-beat burst
//   burst_bytes()  : per-instance burst stride from data width and burst length
package ddr_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wr_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned BYTES_PER_BEAT = 128 / 8;
    localparam int unsigned BURST_BYTES    = 16 * BYTES_PER_BEAT;

    function automatic int unsigned burst_bytes(input int unsigned data_w,
                                                input int unsigned burst_len);
        return burst_len * (data_w / 8);
    endfunction

endpackage

// File: rtl/ddr_wr_burst_ctrl_skid2.sv
// ddr_wr_skid2: two-entry skid buffer that catches FIFO read data arriving one
// cycle after the read enable, so the AXI W channel can stall freely.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : store push_data this cycle
//   pop        : drop the head entry this cycle
//   head       : oldest entry (held stable until popped)
//   count      : occupancy 0..2
module ddr_wr_skid2
    import ddr_wr_pkg::*;
#(
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;

    // q0 is always the head; it only changes on a pop or on a push into an
    // empty buffer, which keeps the W-channel payload stable during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0    <= '0;
            q1    <= '0;
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) q0 <= push_data;
                    else               q1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0    <= q1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q0 <= push_data;
                    end else begin
                        q0 <= q1;
                        q1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = q0;

endmodule

// File: rtl/ddr_wr_burst_ctrl.sv
// ddr_wr_burst_ctrl: drains full bursts from the write-DDR FIFO into AXI4
// write transactions, walking a linear frame region and wrapping at its end.
//   rd_clk / rd_rst        : FIFO read / AXI clock, async active-high reset
//   frame_start            : restart the frame at FRAME_BASE (deferred if busy)
//   fifo_rd_*              : FIFO read side (1-cycle read latency)
//   aw* / w* / b*          : AXI4 write address, data and response channels
//   frame_done             : 1-cycle pulse after the last burst of a frame
//   busy                   : FSM not in IDLE
// Optional build macro DDR_WR_BRESP_ERR_CNT_EN adds err_cnt / err_flag, which
// count non-OKAY write responses (saturating, sticky flag, cleared on reset).
module ddr_wr_burst_ctrl
    import ddr_wr_pkg::*;
#(
    parameter int unsigned        DATA_W       = 128,
    parameter int unsigned        FIFO_DEPTH_W = 10,
    parameter int unsigned        ADDR_W       = 28,
    parameter int unsigned        BURST_LEN    = 16,
    parameter logic [ADDR_W-1:0]  FRAME_BASE   = '0,
    parameter int unsigned        FRAME_BEATS  = 259200
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic                    frame_start,
    output logic                    fifo_rd_en,
    input  logic [DATA_W-1:0]       fifo_rd_data,
    input  logic                    fifo_rd_empty,
    input  logic [FIFO_DEPTH_W:0]   fifo_rd_water_level,
    output logic [ADDR_W-1:0]       awaddr,
    output logic [7:0]              awlen,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_W-1:0]       wdata,
    output logic [DATA_W/8-1:0]     wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    frame_done,
    output logic                    busy
`ifdef DDR_WR_BRESP_ERR_CNT_EN
    ,
    output logic [15:0]             err_cnt,
    output logic                    err_flag
`endif
);

    localparam int unsigned          CNT_W     = $clog2(FRAME_BEATS + 1);
    localparam logic [ADDR_W-1:0]    ADDR_STEP = ADDR_W'(burst_bytes(DATA_W, BURST_LEN));
    localparam logic [CNT_W-1:0]     CNT_STEP  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]     CNT_END   = CNT_W'(FRAME_BEATS);
    localparam logic [FIFO_DEPTH_W:0] LVL_BURST = (FIFO_DEPTH_W + 1)'(BURST_LEN);
    localparam logic [8:0]           RD_MAX    = 9'(BURST_LEN);
    localparam logic [7:0]           LAST_BEAT = 8'(BURST_LEN - 1);

    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [CNT_W-1:0]  frame_cnt;
    logic              pending;
    logic [8:0]        rd_issued;
    logic [7:0]        wbeat;
    logic              inflight;
    logic [1:0]        skid_count;
    logic [DATA_W-1:0] skid_head;
    logic              burst_start;
    logic              w_pop;

    assign burst_start = (state == IDLE) && (fifo_rd_water_level >= LVL_BURST);

    // Constant channel fields still read as zero while reset is held.
    assign awlen = rd_rst ? '0 : LAST_BEAT;
    assign wstrb = rd_rst ? '0 : '1;
    assign wdata = skid_head;

    ddr_wr_skid2 #(.DATA_W(DATA_W)) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (w_pop),
        .head      (skid_head),
        .count     (skid_count)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (burst_start)    state_nxt = AW;
            AW:      if (awready)        state_nxt = W;
            W:       if (w_pop && wlast) state_nxt = B;
            B:       if (bvalid)         state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Reads are throttled so data already in the skid buffer plus the read
    // still in flight never exceeds the two available entries.
    always_comb begin
        awvalid    = (state == AW);
        bready     = (state == B);
        busy       = (state != IDLE);
        wvalid     = (state == W) && (skid_count != 2'd0);
        wlast      = wvalid && (wbeat == LAST_BEAT);
        w_pop      = wvalid && wready;
        fifo_rd_en = (state == W) && !fifo_rd_empty && (rd_issued < RD_MAX) &&
                     (({1'b0, skid_count} + {2'b00, inflight}) < 3'd2);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            awaddr     <= FRAME_BASE;
            frame_cnt  <= '0;
            pending    <= 1'b0;
            rd_issued  <= '0;
            wbeat      <= '0;
            inflight   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            inflight   <= fifo_rd_en;
            frame_done <= 1'b0;

            if (state == IDLE) begin
                rd_issued <= '0;
                wbeat     <= '0;
            end else begin
                if (fifo_rd_en) rd_issued <= rd_issued + 9'd1;
                if (w_pop)      wbeat     <= wbeat + 8'd1;
            end

            // A start request seen while a burst is starting or in flight is
            // parked and applied when the following burst begins.
            if (burst_start) begin
                if (pending) begin
                    awaddr    <= FRAME_BASE;
                    frame_cnt <= '0;
                end
                pending <= frame_start;
            end else if (state == IDLE) begin
                if (frame_start) begin
                    awaddr    <= FRAME_BASE;
                    frame_cnt <= '0;
                    pending   <= 1'b0;
                end
            end else begin
                if (frame_start) pending <= 1'b1;
                if ((state == B) && bvalid) begin
                    if (frame_cnt + CNT_STEP == CNT_END) begin
                        awaddr     <= FRAME_BASE;
                        frame_cnt  <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        awaddr    <= awaddr + ADDR_STEP;
                        frame_cnt <= frame_cnt + CNT_STEP;
                    end
                end
            end
        end
    end

`ifdef DDR_WR_BRESP_ERR_CNT_EN
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (bvalid && bready && (bresp != AXI_RESP_OKAY)) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            err_flag <= 1'b1;
        end
    end
`else
    // bresp does not steer control flow in this build.
    logic unused_bresp;
    assign unused_bresp = ^bresp;
`endif

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// tb_ddr_wr_burst_ctrl: self-checking bench for ddr_wr_burst_ctrl with a small
// frame (FRAME_BEATS = 64, four 16-beat bursts). A queue-based FIFO model
// feeds the DUT; expected addresses come from the frame position in beats.
// Define DDR_WR_BRESP_ERR_CNT_EN to also check err_cnt / err_flag.
module tb_ddr_wr_burst_ctrl;

    localparam int DATA_W       = 128;
    localparam int FIFO_DEPTH_W = 10;
    localparam int ADDR_W       = 28;
    localparam int BURST_LEN    = 16;
    localparam int FRAME_BEATS  = 64;
    localparam int BURST_BYTES  = BURST_LEN * DATA_W / 8;
    localparam logic [ADDR_W-1:0] FRAME_BASE = '0;

    logic                  rd_clk = 1'b0;
    logic                  rd_rst = 1'b1;
    logic                  frame_start = 1'b0;
    logic                  fifo_rd_en;
    logic [DATA_W-1:0]     fifo_rd_data = '0;
    logic                  fifo_rd_empty = 1'b1;
    logic [FIFO_DEPTH_W:0] fifo_rd_water_level = '0;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready = 1'b0;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready = 1'b0;
    logic [1:0]            bresp = 2'b00;
    logic                  bvalid = 1'b0;
    logic                  bready;
    logic                  frame_done;
    logic                  busy;
`ifdef DDR_WR_BRESP_ERR_CNT_EN
    logic [15:0]           err_cnt;
    logic                  err_flag;
`endif

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] exp_q[$];
    int rd_total  = 0;
    int underflow = 0;
    int fd_total  = 0;

    // reference model: frame position in beats plus a pending restart
    int m_beats   = 0;
    bit m_pending = 0;
    int m_frames  = 0;

    // per-burst observations
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_len;
    int b_beats, b_wl, b_db, b_un, b_occ, b_rd, b_to;

    ddr_wr_burst_ctrl #(
        .DATA_W       (DATA_W),
        .FIFO_DEPTH_W (FIFO_DEPTH_W),
        .ADDR_W       (ADDR_W),
        .BURST_LEN    (BURST_LEN),
        .FRAME_BASE   (FRAME_BASE),
        .FRAME_BEATS  (FRAME_BEATS)
    ) dut (
        .rd_clk              (rd_clk),
        .rd_rst              (rd_rst),
        .frame_start         (frame_start),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .awaddr              (awaddr),
        .awlen               (awlen),
        .awvalid             (awvalid),
        .awready             (awready),
        .wdata               (wdata),
        .wstrb               (wstrb),
        .wlast               (wlast),
        .wvalid              (wvalid),
        .wready              (wready),
        .bresp               (bresp),
        .bvalid              (bvalid),
        .bready              (bready),
        .frame_done          (frame_done),
        .busy                (busy)
`ifdef DDR_WR_BRESP_ERR_CNT_EN
        ,
        .err_cnt             (err_cnt),
        .err_flag            (err_flag)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: data one cycle after the read enable, registered flags
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            rd_total++;
            if (fq.size() == 0) underflow++;
            else fifo_rd_data <= fq.pop_front();
        end
        fifo_rd_water_level <= (FIFO_DEPTH_W + 1)'(fq.size());
        fifo_rd_empty       <= (fq.size() == 0);
    end

    always @(posedge rd_clk) if (frame_done) fd_total++;

    function automatic logic [ADDR_W-1:0] model_addr();
        return FRAME_BASE + ADDR_W'((m_beats / BURST_LEN) * BURST_BYTES);
    endfunction

    task automatic model_start();
        if (m_pending) begin
            m_beats   = 0;
            m_pending = 0;
        end
    endtask

    task automatic model_done();
        m_beats += BURST_LEN;
        if (m_beats == FRAME_BEATS) begin
            m_beats = 0;
            m_frames++;
        end
    endtask

    task automatic push_words(input int n);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            fq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    // Plays the AXI slave for one burst and records what it saw.
    // fs_beat >= 0 pulses frame_start twice during W; abort_beat >= 0 leaves
    // the burst after that many accepted beats.
    task automatic do_burst(input int stall_pct, input logic [1:0] resp,
                            input int fs_beat, input int abort_beat);
        int rd_base, cyc, fs_n, lat, occ;
        bit stalled;
        logic [DATA_W-1:0] hold_d, e;
        logic hold_l;
        b_addr = '0; b_len = '0; b_beats = 0; b_wl = 0; b_db = 0; b_un = 0;
        b_occ = 0; b_rd = 0; b_to = 0; stalled = 0; fs_n = 0; cyc = 0;
        hold_d = '0; hold_l = 1'b0;
        rd_base = rd_total;
        while (1) begin
            @(negedge rd_clk);
            if (awvalid) begin
                if (cyc > 0 && b_len == awlen && b_addr !== awaddr) b_un++;
                b_addr = awaddr;
                b_len  = awlen;
                awready = ($urandom_range(0, 1) == 1);
                if (awready) break;
            end
            cyc++;
            if (cyc > 200) begin b_to++; return; end
        end
        @(posedge rd_clk);
        #1 awready = 1'b0;
        cyc = 0;
        while (1) begin
            @(negedge rd_clk);
            frame_start = 1'b0;
            if (fs_beat >= 0 && fs_n < 2 && b_beats >= fs_beat + 3 * fs_n) begin
                frame_start = 1'b1;
                fs_n++;
            end
            if (abort_beat >= 0 && b_beats >= abort_beat) begin
                wready = 1'b0;
                return;
            end
            occ = rd_total - rd_base - b_beats;
            if (occ > b_occ) b_occ = occ;
            if (stalled && (!wvalid || wdata !== hold_d || wlast !== hold_l)) b_un++;
            if (wvalid) begin
                wready = ($urandom_range(0, 99) >= stall_pct);
                if (wready) begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    else e = 'x;
                    if (wdata !== e) b_db++;
                    if (wlast !== (b_beats == BURST_LEN - 1)) b_wl++;
                    b_beats++;
                    stalled = 0;
                    if (wlast || b_beats > BURST_LEN) break;
                end else begin
                    stalled = 1;
                    hold_d  = wdata;
                    hold_l  = wlast;
                end
            end else begin
                wready  = ($urandom_range(0, 1) == 1);
                stalled = 0;
            end
            cyc++;
            if (cyc > 2000) begin b_to++; wready = 1'b0; return; end
        end
        @(posedge rd_clk);
        lat = $urandom_range(0, 3);
        cyc = 0;
        while (1) begin
            @(negedge rd_clk);
            frame_start = 1'b0;
            wready      = 1'b0;
            if (bready) begin
                if (lat == 0) begin
                    bvalid = 1'b1;
                    bresp  = resp;
                    break;
                end
                lat--;
            end
            cyc++;
            if (cyc > 200) begin b_to++; return; end
        end
        @(posedge rd_clk);
        @(negedge rd_clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        b_rd   = rd_total - rd_base;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge rd_clk);
        tests++;
        if ({awvalid, wvalid, wlast, bready, fifo_rd_en, busy, frame_done} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0", {awvalid, wvalid, wlast, bready, fifo_rd_en, busy, frame_done});
        end
        tests++;
        if (awaddr !== FRAME_BASE || awlen !== 8'h0 || wstrb !== '0 || wdata !== '0) begin
            fails++;
            $display("FAIL reset_data: got addr %0h len %0h strb %0h data %0h expected all 0", awaddr, awlen, wstrb, wdata);
        end
        rd_rst = 1'b0;
        @(negedge rd_clk);
        tests++;
        if (awlen !== 8'(BURST_LEN - 1) || wstrb !== {(DATA_W/8){1'b1}} || busy !== 1'b0) begin
            fails++;
            $display("FAIL const_out: got len %0h strb %0h busy %b expected len %0h strb all ones busy 0", awlen, wstrb, busy, BURST_LEN - 1);
        end
    endtask

    task automatic test_threshold();
        bit saw_aw;
        int rd0;
        logic [ADDR_W-1:0] ea;
        push_words(BURST_LEN - 1);
        saw_aw = 0;
        rd0 = rd_total;
        repeat (20) begin
            @(negedge rd_clk);
            if (awvalid || busy) saw_aw = 1;
        end
        tests++;
        if (saw_aw !== 1'b0 || rd_total !== rd0) begin
            fails++;
            $display("FAIL below_thresh: got started %b reads %0d expected 0 0", saw_aw, rd_total - rd0);
        end
        push_words(1);
        for (int k = 0; k < 2; k++) begin
            model_start();
            ea = model_addr();
            do_burst(0, 2'b00, -1, -1);
            model_done();
            tests++;
            if (b_to !== 0 || b_addr !== ea || b_len !== 8'(BURST_LEN - 1)) begin
                fails++;
                $display("FAIL thr_aw%0d: got addr %0h len %0d to %0d expected addr %0h len %0d to 0", k, b_addr, b_len, b_to, ea, BURST_LEN - 1);
            end
            tests++;
            if (b_beats !== BURST_LEN || b_rd !== BURST_LEN || b_wl !== 0 || b_db !== 0) begin
                fails++;
                $display("FAIL thr_w%0d: got beats %0d reads %0d wlast_err %0d data_err %0d expected %0d %0d 0 0", k, b_beats, b_rd, b_wl, b_db, BURST_LEN, BURST_LEN);
            end
            if (k == 0) push_words(BURST_LEN);
        end
    endtask

    task automatic test_stall_wrap();
        logic [ADDR_W-1:0] ea;
        push_words(2 * BURST_LEN);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) push_words(BURST_LEN);
            model_start();
            ea = model_addr();
            do_burst(50, 2'b00, -1, -1);
            model_done();
            tests++;
            if (busy !== 1'b0 || awvalid !== 1'b0) begin
                fails++;
                $display("FAIL gap%0d: got busy %b awvalid %b expected 0 0", k, busy, awvalid);
            end
            tests++;
            if (b_to !== 0 || b_addr !== ea || b_un !== 0 || b_occ > 2) begin
                fails++;
                $display("FAIL stall_aw%0d: got addr %0h unstable %0d occ %0d to %0d expected addr %0h 0 <=2 0", k, b_addr, b_un, b_occ, b_to, ea);
            end
            tests++;
            if (b_beats !== BURST_LEN || b_rd !== BURST_LEN || b_wl !== 0 || b_db !== 0 || underflow !== 0) begin
                fails++;
                $display("FAIL stall_w%0d: got beats %0d reads %0d wlast_err %0d data_err %0d underflow %0d expected %0d %0d 0 0 0", k, b_beats, b_rd, b_wl, b_db, underflow, BURST_LEN, BURST_LEN);
            end
            if (k == 1) begin
                repeat (2) @(negedge rd_clk);
                tests++;
                if (fd_total !== m_frames) begin
                    fails++;
                    $display("FAIL frame_done: got %0d pulse cycles expected %0d", fd_total, m_frames);
                end
            end
        end
    endtask

    task automatic test_frame_start();
        logic [ADDR_W-1:0] ea;
        for (int k = 0; k < 4; k++) begin
            push_words(BURST_LEN);
            model_start();
            ea = model_addr();
            if (k == 1) begin
                do_burst(30, 2'b00, 4, -1);
                m_pending = 1;
            end else begin
                do_burst(30, 2'b00, -1, -1);
            end
            model_done();
            tests++;
            if (b_to !== 0 || b_addr !== ea || b_db !== 0 || b_beats !== BURST_LEN) begin
                fails++;
                $display("FAIL fs_burst%0d: got addr %0h beats %0d data_err %0d to %0d expected addr %0h beats %0d 0 0", k, b_addr, b_beats, b_db, b_to, ea, BURST_LEN);
            end
        end
        // idle restart: no burst can start (FIFO empty), so it applies at once
        frame_start = 1'b1;
        @(negedge rd_clk);
        frame_start = 1'b0;
        m_beats = 0;
        repeat (2) @(negedge rd_clk);
        push_words(BURST_LEN);
        model_start();
        ea = model_addr();
        do_burst(0, 2'b00, -1, -1);
        model_done();
        repeat (2) @(negedge rd_clk);
        tests++;
        if (b_addr !== ea || fd_total !== m_frames) begin
            fails++;
            $display("FAIL fs_idle: got addr %0h frame_done %0d expected addr %0h frame_done %0d", b_addr, fd_total, ea, m_frames);
        end
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] ea;
        push_words(BURST_LEN);
        model_start();
        do_burst(20, 2'b00, -1, 5);
        #2 rd_rst = 1'b1;
        #1;
        tests++;
        if ({awvalid, wvalid, wlast, bready, fifo_rd_en, busy, frame_done} !== 7'b0 ||
            awaddr !== FRAME_BASE || wdata !== '0 || awlen !== 8'h0 || wstrb !== '0) begin
            fails++;
            $display("FAIL async_rst: got ctrl %b addr %0h data %0h expected all 0",
                     {awvalid, wvalid, wlast, bready, fifo_rd_en, busy, frame_done}, awaddr, wdata);
        end
        fq.delete();
        exp_q.delete();
        m_beats = 0;
        m_pending = 0;
        repeat (3) @(negedge rd_clk);
        rd_rst = 1'b0;
        repeat (2) @(negedge rd_clk);
        push_words(BURST_LEN);
        model_start();
        ea = model_addr();
        do_burst(20, 2'b00, -1, -1);
        model_done();
        tests++;
        if (b_to !== 0 || b_addr !== ea || b_db !== 0 || b_beats !== BURST_LEN || b_wl !== 0) begin
            fails++;
            $display("FAIL post_rst: got addr %0h beats %0d data_err %0d wlast_err %0d expected addr %0h beats %0d 0 0", b_addr, b_beats, b_db, b_wl, ea, BURST_LEN);
        end
    endtask

    task automatic test_bresp();
        logic [ADDR_W-1:0] ea;
`ifdef DDR_WR_BRESP_ERR_CNT_EN
        tests++;
        if (err_cnt !== 16'd0 || err_flag !== 1'b0) begin
            fails++;
            $display("FAIL err_init: got cnt %0d flag %b expected 0 0", err_cnt, err_flag);
        end
`endif
        for (int k = 0; k < 4; k++) begin
            push_words(BURST_LEN);
            model_start();
            ea = model_addr();
            do_burst(25, (k < 3) ? 2'b10 : 2'b00, -1, -1);
            model_done();
            tests++;
            if (b_to !== 0 || b_addr !== ea || b_db !== 0) begin
                fails++;
                $display("FAIL bresp_burst%0d: got addr %0h data_err %0d to %0d expected addr %0h 0 0", k, b_addr, b_db, b_to, ea);
            end
        end
        repeat (2) @(negedge rd_clk);
        tests++;
        if (fd_total !== m_frames) begin
            fails++;
            $display("FAIL frame_done2: got %0d expected %0d", fd_total, m_frames);
        end
`ifdef DDR_WR_BRESP_ERR_CNT_EN
        tests++;
        if (err_cnt !== 16'd3 || err_flag !== 1'b1) begin
            fails++;
            $display("FAIL err_cnt: got cnt %0d flag %b expected 3 1", err_cnt, err_flag);
        end
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_threshold();
        test_stall_wrap();
        test_frame_start();
        test_reset_mid();
        test_bresp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
